// File: rtl/wb_pkg.sv
// wb_pkg: shared types and constants for the writeback controller.
//   wb_state_t     : controller FSM states
//   REG_ADDR_W     : register file address width
//   DATA_W         : register file data width
//   PC_REG         : register index that aliases the program counter
//   TIMEOUT_CYCLES : WAIT_MEM cycles before a load is abandoned
//                    (only meaningful when WB_TIMEOUT_EN is defined)
package wb_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_MEM = 2'd1,
        WRITE    = 2'd2
    } wb_state_t;

    localparam int REG_ADDR_W     = 4;
    localparam int DATA_W         = 32;
    localparam int TIMEOUT_CYCLES = 8;

    localparam logic [REG_ADDR_W-1:0] PC_REG = 4'd15;

endpackage

// File: rtl/wb_ctrl_if.sv
// wb_ctrl_if: retire handshake from execute plus the DMEM read response.
//   master : execute / memory side (drives instruction fields, DMEM response)
//   slave  : writeback controller (drives EX_ready)
interface wb_ctrl_if;
    import wb_pkg::*;

    logic                  EX_valid;
    logic                  EX_ready;
    logic [REG_ADDR_W-1:0] EX_ARd;
    logic                  EX_write_en;
    logic                  EX_is_load;
    logic [DATA_W-1:0]     EX_ALU_result;
    logic                  DMEM_rvalid;
    logic [DATA_W-1:0]     DMEM_rdata;

    modport master (
        output EX_valid, EX_ARd, EX_write_en, EX_is_load, EX_ALU_result,
        output DMEM_rvalid, DMEM_rdata,
        input  EX_ready
    );

    modport slave (
        input  EX_valid, EX_ARd, EX_write_en, EX_is_load, EX_ALU_result,
        input  DMEM_rvalid, DMEM_rdata,
        output EX_ready
    );
endinterface

// File: rtl/wb_pc_next.sv
// wb_pc_next: program counter register.
//   clk_i, rst_i : clock, synchronous active-high reset
//   advance_i    : one retirement completed this cycle
//   branch_i     : the retirement wrote the PC register (takes priority)
//   target_i     : branch target
//   pc_o         : current PC_next value
module wb_pc_next #(
    parameter int NUM_INSTR = 16,
    parameter int PC_W      = 5
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            advance_i,
    input  logic            branch_i,
    input  logic [PC_W-1:0] target_i,
    output logic [PC_W-1:0] pc_o
);

    logic [PC_W-1:0] pc_q;
    logic [PC_W-1:0] pc_d;

    always_comb begin
        pc_d = pc_q;
        if (branch_i) begin
            pc_d = target_i;
        end else if (advance_i) begin
            pc_d = (pc_q == PC_W'(NUM_INSTR - 1)) ? '0 : pc_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pc_q <= '0;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc_o = pc_q;

endmodule

// File: rtl/wb_ctrl.sv
// wb_ctrl: writeback controller; retires one instruction at a time with a
// single register-file write and then advances (or branches) the PC.
//   CLOCK_50, RESET             : clock, synchronous active-high reset
//   ex (wb_ctrl_if.slave)       : retire handshake and DMEM read response
//   mux_ARd_or_15               : register file write address
//   CNTRL_write_en_ARd          : register file write enable (WRITE only)
//   mux_ALU_result_or_DMEM_data : register file write data
//   PC_next                     : next PC, stable between retirements
//   WB_busy                     : controller not in IDLE
//   WB_timeout                  : sticky load-timeout flag
// Optional: define WB_TIMEOUT_EN to abandon loads after TIMEOUT_CYCLES.
//
// state    | meaning
// IDLE     | ready for the next retiring instruction
// WAIT_MEM | load accepted, waiting for DMEM_rvalid
// WRITE    | one-cycle register write, PC updated at end of cycle
module wb_ctrl
    import wb_pkg::*;
#(
    parameter int NUM_INSTR = 16,
    parameter int PC_W      = 5
) (
    input  logic                  CLOCK_50,
    input  logic                  RESET,
    wb_ctrl_if.slave              ex,
    output logic [REG_ADDR_W-1:0] mux_ARd_or_15,
    output logic                  CNTRL_write_en_ARd,
    output logic [DATA_W-1:0]     mux_ALU_result_or_DMEM_data,
    output logic [PC_W-1:0]       PC_next,
    output logic                  WB_busy,
    output logic                  WB_timeout
);

    wb_state_t             state_q, state_d;
    logic [REG_ADDR_W-1:0] ard_q, ard_d;
    logic                  wen_q, wen_d;
    logic [DATA_W-1:0]     data_q, data_d;
    logic                  wr_en_q, wr_en_d;
    logic                  ready_q, busy_q;
    logic                  advance;
    logic                  branch;

`ifdef WB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES);
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             tmo_q, tmo_set;
`endif

    always_comb begin
        state_d = state_q;
        ard_d   = ard_q;
        wen_d   = wen_q;
        data_d  = data_q;
        wr_en_d = 1'b0;
        advance = 1'b0;
`ifdef WB_TIMEOUT_EN
        cnt_d   = cnt_q;
        tmo_set = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                // A coincident DMEM_rvalid here belongs to nobody and is dropped.
                if (ex.EX_valid && ready_q) begin
                    ard_d = ex.EX_ARd;
                    wen_d = ex.EX_write_en;
                    if (ex.EX_is_load) begin
                        state_d = WAIT_MEM;
`ifdef WB_TIMEOUT_EN
                        cnt_d   = '0;
`endif
                    end else begin
                        data_d  = ex.EX_ALU_result;
                        wr_en_d = ex.EX_write_en;
                        state_d = WRITE;
                    end
                end
            end
            WAIT_MEM: begin
                // rvalid is checked first so it wins over a same-cycle expiry.
                if (ex.DMEM_rvalid) begin
                    data_d  = ex.DMEM_rdata;
                    wr_en_d = wen_q;
                    state_d = WRITE;
`ifdef WB_TIMEOUT_EN
                end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    tmo_set = 1'b1;
                    state_d = WRITE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
`endif
                end
            end
            WRITE: begin
                advance = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Branch only when the write really happens (a timed-out load never branches).
    assign branch = advance && wr_en_q && (ard_q == PC_REG);

    always_ff @(posedge CLOCK_50) begin
        if (RESET) begin
            state_q <= IDLE;
            ard_q   <= '0;
            wen_q   <= 1'b0;
            data_q  <= '0;
            wr_en_q <= 1'b0;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ard_q   <= ard_d;
            wen_q   <= wen_d;
            data_q  <= data_d;
            wr_en_q <= wr_en_d;
            ready_q <= (state_d == IDLE);
            busy_q  <= (state_d != IDLE);
        end
    end

`ifdef WB_TIMEOUT_EN
    always_ff @(posedge CLOCK_50) begin
        if (RESET) begin
            cnt_q <= '0;
            tmo_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            if (tmo_set) begin
                tmo_q <= 1'b1;
            end
        end
    end
    assign WB_timeout = tmo_q;
`else
    assign WB_timeout = 1'b0;
`endif

    wb_pc_next #(
        .NUM_INSTR (NUM_INSTR),
        .PC_W      (PC_W)
    ) u_pc_next (
        .clk_i     (CLOCK_50),
        .rst_i     (RESET),
        .advance_i (advance),
        .branch_i  (branch),
        .target_i  (data_q[PC_W-1:0]),
        .pc_o      (PC_next)
    );

    assign ex.EX_ready                 = ready_q;
    assign mux_ARd_or_15               = ard_q;
    assign CNTRL_write_en_ARd          = wr_en_q;
    assign mux_ALU_result_or_DMEM_data = data_q;
    assign WB_busy                     = busy_q;

endmodule
